// File: rtl/demux_1_to_n_stream_pkg.sv
`default_nettype none
// ============================================================================
// Module      : demux_pkg
// Description : Shared constants and helpers for the 1-to-N stream demux.
//               Holds the default beat width and channel count, plus the
//               ceiling-log2 function used to size the channel select.
// Ports       : (package - none)
// Revision    : 1.0 - initial release
// ============================================================================
package demux_pkg;

    localparam int c_default_data_width = 8;
    localparam int c_default_num_ch     = 4;

    // Ceiling log2, with a minimum of 1 for any value >= 2.
    function automatic int clog2(input int value);
        int result;
        result = 0;
        for (int i = 0; i < 31; i++) begin
            if ((1 << i) < value) begin
                result = i + 1;
            end
        end
        return result;
    endfunction

endpackage
`default_nettype wire

// File: rtl/demux_1_to_n_stream_if.sv
`default_nettype none
// ============================================================================
// Module      : demux_1_to_n_stream_if
// Description : Handshake bundle for the 1-to-N stream demux. One input
//               stream (data/select/valid/ready) fans out to NUM_CH
//               valid/ready output channels; error status rides alongside.
// Ports       : i_Data, i_Sel, i_Valid, o_Ready  - input stream
//               o_Data, o_Valid, i_Ready         - packed output channels
//               o_Sel_Err, o_Err_Count           - dropped-beat status
//               modport slave  : demux side
//               modport master : stream source / channel sinks side
// Revision    : 1.0 - initial release
// ============================================================================
interface demux_1_to_n_stream_if
    import demux_pkg::*;
#(
    parameter int DATA_WIDTH = c_default_data_width,
    parameter int NUM_CH     = c_default_num_ch,
    parameter int SEL_WIDTH  = clog2(NUM_CH)
);

    logic [DATA_WIDTH-1:0]        i_Data;
    logic [SEL_WIDTH-1:0]         i_Sel;
    logic                         i_Valid;
    logic                         o_Ready;
    logic [NUM_CH*DATA_WIDTH-1:0] o_Data;
    logic [NUM_CH-1:0]            o_Valid;
    logic [NUM_CH-1:0]            i_Ready;
    logic                         o_Sel_Err;
    logic [7:0]                   o_Err_Count;

    modport slave (
        input  i_Data, i_Sel, i_Valid, i_Ready,
        output o_Ready, o_Data, o_Valid, o_Sel_Err, o_Err_Count
    );

    modport master (
        output i_Data, i_Sel, i_Valid, i_Ready,
        input  o_Ready, o_Data, o_Valid, o_Sel_Err, o_Err_Count
    );

endinterface
`default_nettype wire

// File: rtl/demux_1_to_n_stream_channel_reg.sv
`default_nettype none
// ============================================================================
// Module      : demux_channel_reg
// Description : One-entry valid/ready output register for a single demux
//               channel. A load always wins over a drain, so a simultaneous
//               drain-and-load replaces the data and keeps valid asserted.
//               A drain alone clears valid but leaves the data untouched.
// Ports       : clk, rst        - clock, synchronous active-high reset
//               i_load          - write i_load_data this edge
//               i_load_data     - beat to store
//               i_drain_ready   - downstream accepts the held beat
//               o_valid, o_data - held beat
// Revision    : 1.0 - initial release
// ============================================================================
module demux_channel_reg #(
    parameter int DATA_WIDTH = 8
) (
    input  wire logic                  clk,
    input  wire logic                  rst,
    input  wire logic                  i_load,
    input  wire logic [DATA_WIDTH-1:0] i_load_data,
    input  wire logic                  i_drain_ready,
    output logic                       o_valid,
    output logic [DATA_WIDTH-1:0]      o_data
);

    logic                  r_valid;
    logic [DATA_WIDTH-1:0] r_data;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_valid <= 1'b0;
            r_data  <= '0;
        end else if (i_load) begin
            r_valid <= 1'b1;
            r_data  <= i_load_data;
        end else if (r_valid && i_drain_ready) begin
            r_valid <= 1'b0;
        end
    end

    assign o_valid = r_valid;
    assign o_data  = r_data;

endmodule
`default_nettype wire

// File: rtl/demux_1_to_n_stream.sv
`default_nettype none
// ============================================================================
// Module      : demux_1_to_n_stream
// Description : Routes one valid/ready input stream to one of NUM_CH output
//               channels selected by i_Sel. Each channel has a one-entry
//               register, giving latency 1 and full per-channel throughput.
//               Beats addressed beyond the last channel are accepted and
//               dropped, flagged by a one-cycle o_Sel_Err pulse and counted
//               in a saturating 8-bit o_Err_Count.
// Ports       : i_Clk  - clock (rising edge)
//               i_Rst  - synchronous active-high reset
//               bus    - demux_1_to_n_stream_if.slave handshake bundle
// Revision    : 1.0 - initial release
// ============================================================================
module demux_1_to_n_stream
    import demux_pkg::*;
#(
    parameter int DATA_WIDTH = c_default_data_width,
    parameter int NUM_CH     = c_default_num_ch,
    parameter int SEL_WIDTH  = clog2(NUM_CH)
) (
    input wire logic             i_Clk,
    input wire logic             i_Rst,
    demux_1_to_n_stream_if.slave bus
);

    // One extra bit so the range check also works when NUM_CH is a power
    // of two (then it can never fire, which is the intended behaviour).
    localparam logic [SEL_WIDTH:0] c_num_ch_ext = NUM_CH[SEL_WIDTH:0];

    logic [SEL_WIDTH:0]           w_sel_ext;
    logic                         w_sel_oor;
    logic                         w_ch_free;
    logic                         w_ready;
    logic                         w_accept;
    logic                         w_drop;
    logic [NUM_CH-1:0]            w_load;
    wire  [NUM_CH-1:0]            w_valid;
    logic [DATA_WIDTH-1:0]        w_ch_data [NUM_CH];
    logic [NUM_CH*DATA_WIDTH-1:0] w_data_flat;

    logic       r_sel_err;
    logic [7:0] r_err_count;

    assign w_sel_ext = {1'b0, bus.i_Sel};
    assign w_sel_oor = (w_sel_ext >= c_num_ch_ext);

    // Selected channel can take a beat if empty or draining this cycle.
    always_comb begin
        w_ch_free = 1'b0;
        w_load    = '0;
        for (int k = 0; k < NUM_CH; k++) begin
            if (bus.i_Sel == SEL_WIDTH'(k)) begin
                w_ch_free = !w_valid[k] || bus.i_Ready[k];
                w_load[k] = w_accept && !w_sel_oor;
            end
        end
    end

    // Out-of-range beats are always accepted so they cannot stall the stream.
    assign w_ready  = !i_Rst && (w_sel_oor || w_ch_free);
    assign w_accept = bus.i_Valid && w_ready;
    assign w_drop   = w_accept && w_sel_oor;

    always_ff @(posedge i_Clk) begin
        if (i_Rst) begin
            r_sel_err   <= 1'b0;
            r_err_count <= 8'd0;
        end else begin
            r_sel_err <= w_drop;
            if (w_drop && (r_err_count != 8'hFF)) begin
                r_err_count <= r_err_count + 8'd1;
            end
        end
    end

    generate
        for (genvar k = 0; k < NUM_CH; k++) begin : g_channel
            demux_channel_reg #(
                .DATA_WIDTH (DATA_WIDTH)
            ) u_channel_reg (
                .clk           (i_Clk),
                .rst           (i_Rst),
                .i_load        (w_load[k]),
                .i_load_data   (bus.i_Data),
                .i_drain_ready (bus.i_Ready[k]),
                .o_valid       (w_valid[k]),
                .o_data        (w_ch_data[k])
            );
        end
    endgenerate

    always_comb begin
        w_data_flat = '0;
        for (int k = 0; k < NUM_CH; k++) begin
            w_data_flat[k*DATA_WIDTH +: DATA_WIDTH] = w_ch_data[k];
        end
    end

    assign bus.o_Ready     = w_ready;
    assign bus.o_Valid     = w_valid;
    assign bus.o_Data      = w_data_flat;
    assign bus.o_Sel_Err   = r_sel_err;
    assign bus.o_Err_Count = r_err_count;

endmodule
`default_nettype wire
